// File: rtl/mem_bus_master.sv
// Initiator-side sequencer for the 13-bit ROM/RAM bus: one CPU access at a time,
// per-region wait states, registered outputs and rejection of writes into ROM.
module mem_bus_master #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ack,
    output logic              err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic              rom_sel,
    output logic              ram_sel
);

    localparam logic [2:0] RomCnt = 3'(ROM_WAIT);
    localparam logic [2:0] RamCnt = 3'(RAM_WAIT);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              bus_rd_q, bus_rd_d;
    logic              bus_wr_q, bus_wr_d;
    logic              rom_sel_q, rom_sel_d;
    logic              ram_sel_q, ram_sel_d;
    logic              req_is_ram;

    // RAM occupies the top quarter of the map (1800H-1FFFH).
    assign req_is_ram = (cpu_addr[ADDR_W-1:ADDR_W-2] == 2'b11);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        bus_rd_d    = 1'b0;
        bus_wr_d    = 1'b0;
        rom_sel_d   = 1'b0;
        ram_sel_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    bus_addr_d  = cpu_addr;
                    bus_wdata_d = cpu_wdata;
                    if (we && !req_is_ram) begin
                        // Write into ROM: never strobe, report the rejection at once.
                        state_d = StDone;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = StAccess;
                        cnt_d     = req_is_ram ? RamCnt : RomCnt;
                        bus_rd_d  = !we;
                        bus_wr_d  = we;
                        ram_sel_d = req_is_ram;
                        rom_sel_d = !req_is_ram;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == 3'd0) begin
                    state_d = StDone;
                    ack_d   = 1'b1;
                    if (bus_rd_q) begin
                        cpu_rdata_d = bus_rdata;
                    end
                end else begin
                    cnt_d     = cnt_q - 3'd1;
                    bus_rd_d  = bus_rd_q;
                    bus_wr_d  = bus_wr_q;
                    rom_sel_d = rom_sel_q;
                    ram_sel_d = ram_sel_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            cpu_rdata_q <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            rom_sel_q   <= 1'b0;
            ram_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            bus_rd_q    <= bus_rd_d;
            bus_wr_q    <= bus_wr_d;
            rom_sel_q   <= rom_sel_d;
            ram_sel_q   <= ram_sel_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_rd    = bus_rd_q;
    assign bus_wr    = bus_wr_q;
    assign rom_sel   = rom_sel_q;
    assign ram_sel   = ram_sel_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a default instance and a ROM_WAIT=0/RAM_WAIT=7 instance,
// table-driven accesses checked by a per-instance scoreboard, plus hand-written corner cases.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  bus_rdata = '0;

    logic [7:0]  cpu_rdata0, cpu_rdata1, bus_wdata0, bus_wdata1;
    logic [12:0] bus_addr0, bus_addr1;
    logic        ack0, err0, bus_rd0, bus_wr0, rom_sel0, ram_sel0;
    logic        ack1, err1, bus_rd1, bus_wr1, rom_sel1, ram_sel1;

    mem_bus_master u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0), .ack(ack0), .err(err0),
        .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_rdata(bus_rdata),
        .bus_rd(bus_rd0), .bus_wr(bus_wr0), .rom_sel(rom_sel0), .ram_sel(ram_sel0)
    );

    mem_bus_master #(.ROM_WAIT(0), .RAM_WAIT(7)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1), .ack(ack1), .err(err1),
        .bus_addr(bus_addr1), .bus_wdata(bus_wdata1), .bus_rdata(bus_rdata),
        .bus_rd(bus_rd1), .bus_wr(bus_wr1), .rom_sel(rom_sel1), .ram_sel(ram_sel1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        exp_err;
        logic        exp_ram;
        int          exp_len;
    } vec_t;

    typedef struct {
        int          t1;
        int          ack_cyc;
        logic        we;
        logic        err;
        logic        ram;
        int          len;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          scnt[2] = '{0, 0};
    logic        prev_ack[2] = '{1'b0, 1'b0};
    logic [7:0]  mdl_rdata[2] = '{8'h00, 8'h00};
    vec_t        vecs[11];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    task automatic mon(input int k, input logic a, input logic e, input logic rd,
                       input logic wr, input logic rs, input logic ms,
                       input logic [12:0] ba, input logic [7:0] bw, input logic [7:0] cr);
        exp_t x;
        logic have;
        if (!rst_n) begin
            scnt[k] = 0;
            prev_ack[k] = 1'b0;
            return;
        end
        have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        if (have) x = (k == 0) ? sb0[0] : sb1[0];
        if (rd || wr) begin
            if (!have) begin
                fail($sformatf("dut%0d unexpected_strobe", k));
            end else begin
                if (scnt[k] == 0) check($sformatf("dut%0d strobe_start", k), 32'(cyc), 32'(x.t1));
                check($sformatf("dut%0d one_strobe", k), 32'(rd) + 32'(wr), 32'd1);
                check($sformatf("dut%0d one_sel", k), 32'(rs) + 32'(ms), 32'd1);
                check($sformatf("dut%0d ram_sel", k), 32'(ms), 32'(x.ram));
                check($sformatf("dut%0d bus_wr", k), 32'(wr), 32'(x.we));
                check($sformatf("dut%0d bus_addr_hold", k), 32'(ba), 32'(x.addr));
                if (x.we) check($sformatf("dut%0d bus_wdata", k), 32'(bw), 32'(x.wdata));
                scnt[k]++;
            end
        end else begin
            check($sformatf("dut%0d sel_without_strobe", k), 32'(rs | ms), 32'd0);
        end
        if (!a) check($sformatf("dut%0d err_without_ack", k), 32'(e), 32'd0);
        if (a) begin
            check($sformatf("dut%0d ack_width", k), 32'(prev_ack[k]), 32'd0);
            if (!have) begin
                fail($sformatf("dut%0d unexpected_ack", k));
            end else begin
                check($sformatf("dut%0d ack_cycle", k), 32'(cyc), 32'(x.ack_cyc));
                check($sformatf("dut%0d err", k), 32'(e), 32'(x.err));
                check($sformatf("dut%0d strobe_len", k), 32'(scnt[k]), 32'(x.len));
                check($sformatf("dut%0d cpu_rdata", k), 32'(cr), 32'(x.rdata));
                check($sformatf("dut%0d bus_addr", k), 32'(ba), 32'(x.addr));
                if (k == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
            end
            scnt[k] = 0;
        end
        prev_ack[k] = a;
    endtask

    always @(negedge clk) begin
        mon(0, ack0, err0, bus_rd0, bus_wr0, rom_sel0, ram_sel0, bus_addr0, bus_wdata0, cpu_rdata0);
        mon(1, ack1, err1, bus_rd1, bus_wr1, rom_sel1, ram_sel1, bus_addr1, bus_wdata1, cpu_rdata1);
    end

    // Expectation for an access whose req is sampled at the coming rising edge + extra cycles.
    task automatic push(input vec_t v, input int delay);
        exp_t x;
        x.t1      = cyc + 1 + delay;
        x.ack_cyc = x.t1 + v.exp_len;
        x.we      = v.we;
        x.err     = v.exp_err;
        x.ram     = v.exp_ram;
        x.len     = v.exp_len;
        x.addr    = v.addr;
        x.wdata   = v.wdata;
        if (!v.we) mdl_rdata[v.k] = v.rdata;
        x.rdata   = mdl_rdata[v.k];
        if (v.k == 0) sb0.push_back(x);
        else          sb1.push_back(x);
    endtask

    task automatic wait_done(input int k);
        for (int i = 0; i < 40; i++) begin
            if ((k == 0 ? sb0.size() : sb1.size()) == 0) break;
            @(negedge clk);
        end
        if ((k == 0 ? sb0.size() : sb1.size()) != 0) begin
            fail($sformatf("dut%0d ack_timeout", k));
            if (k == 0) sb0.delete();
            else        sb1.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        we        = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        bus_rdata = v.rdata;
        if (v.k == 0) req0 = 1'b1;
        else          req1 = 1'b1;
        push(v, 0);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_done(v.k);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        //          k  we    addr      wdata  rdata  err   ram   len
        vecs[0]  = '{0, 1'b0, 13'h0123, 8'h00, 8'hA5, 1'b0, 1'b0, 3};
        vecs[1]  = '{0, 1'b1, 13'h1800, 8'h3C, 8'h00, 1'b0, 1'b1, 2};
        vecs[2]  = '{0, 1'b1, 13'h17FF, 8'h99, 8'h00, 1'b1, 1'b0, 0};
        vecs[3]  = '{0, 1'b0, 13'h1FFF, 8'h00, 8'h4E, 1'b0, 1'b1, 2};
        vecs[4]  = '{0, 1'b0, 13'h0000, 8'h00, 8'h11, 1'b0, 1'b0, 3};
        vecs[5]  = '{0, 1'b0, 13'h1000, 8'h00, 8'h22, 1'b0, 1'b0, 3};
        vecs[6]  = '{0, 1'b1, 13'h0800, 8'h55, 8'h00, 1'b1, 1'b0, 0};
        vecs[7]  = '{1, 1'b0, 13'h0123, 8'h00, 8'h6B, 1'b0, 1'b0, 1};
        vecs[8]  = '{1, 1'b1, 13'h1FFF, 8'hE7, 8'h00, 1'b0, 1'b1, 8};
        vecs[9]  = '{1, 1'b0, 13'h1800, 8'h00, 8'hD2, 1'b0, 1'b1, 8};
        vecs[10] = '{1, 1'b1, 13'h0000, 8'h01, 8'h00, 1'b1, 1'b0, 0};

        repeat (3) @(negedge clk);
        check("reset_outputs0", {cpu_rdata0, bus_wdata0, bus_addr0, ack0, err0, bus_rd0},
              32'd0);
        check("reset_outputs1", {cpu_rdata1, bus_wdata1, bus_addr1, ack1, err1, bus_rd1},
              32'd0);
        check("reset_strobes", {bus_wr0, rom_sel0, ram_sel0, bus_wr1, rom_sel1, ram_sel1},
              32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // req held high across two RAM reads: second access follows one idle cycle.
        @(negedge clk);
        we        = 1'b0;
        cpu_addr  = 13'h1FFF;
        bus_rdata = 8'h5A;
        req0      = 1'b1;
        v = '{0, 1'b0, 13'h1FFF, 8'h00, 8'h5A, 1'b0, 1'b1, 2};
        push(v, 0);
        v = '{0, 1'b0, 13'h1800, 8'h00, 8'hC3, 1'b0, 1'b1, 2};
        push(v, 4);
        @(negedge clk);
        cpu_addr = 13'h1800;
        for (int i = 0; i < 10 && sb0.size() > 1; i++) @(negedge clk);
        bus_rdata = 8'hC3;
        repeat (2) @(negedge clk);
        req0 = 1'b0;
        wait_done(0);
        @(negedge clk);

        // Reset in the second ACCESS cycle of a ROM read abandons the access.
        @(negedge clk);
        we        = 1'b0;
        cpu_addr  = 13'h0456;
        bus_rdata = 8'h77;
        req0      = 1'b1;
        v = '{0, 1'b0, 13'h0456, 8'h00, 8'h77, 1'b0, 1'b0, 3};
        push(v, 0);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk);
        #2;
        check("pre_reset_bus_rd", 32'(bus_rd0), 32'd1);
        rst_n = 1'b0;
        sb0.delete();
        mdl_rdata[0] = 8'h00;
        mdl_rdata[1] = 8'h00;
        #1;
        check("async_reset_strobe", {bus_rd0, rom_sel0, ram_sel0, ack0}, 32'd0);
        check("async_reset_rdata", 32'(cpu_rdata0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_rdata", 32'(cpu_rdata0), 32'd0);
        check("post_reset_idle", {ack0, bus_rd0, rom_sel0}, 32'd0);

        // A legal access still works after the abandoned one.
        v = '{0, 1'b0, 13'h1FFF, 8'h00, 8'h81, 1'b0, 1'b1, 2};
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator-side sequencer for the 13-bit ROM/RAM memory bus.
- Accepts one CPU access at a time through a req/ack handshake.
- Drives the bus address and the read/write strobes, and inserts per-region wait states.
- Returns read data to the CPU and flags illegal writes into the ROM region.
- Memory map is fixed: 1800H–1FFFH is RAM; 0000H–17FFH is ROM. A region is RAM when addr[12:11]==2'b11.

Parameters:
- ADDR_W, 13, width of CPU and bus addresses.
- DATA_W, 8, width of the data paths.
- ROM_WAIT, 2, number of extra strobe cycles for a ROM access (0..7).
- RAM_WAIT, 1, number of extra strobe cycles for a RAM access (0..7).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  CPU access request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- cpu_addr  input  ADDR_W  access address; sampled with req.
- cpu_wdata  input  DATA_W  write data; sampled with req.
- cpu_rdata  output  DATA_W  last read data; registered.
- ack  output  1  one-cycle completion pulse.
- err  output  1  valid with ack; 1 = write to ROM was rejected.
- bus_addr  output  ADDR_W  latched access address.
- bus_wdata  output  DATA_W  latched write data.
- bus_rdata  input  DATA_W  read data from the selected memory.
- bus_rd  output  1  read strobe.
- bus_wr  output  1  write strobe.
- rom_sel  output  1  ROM chip select; high only while a strobe is high.
- ram_sel  output  1  RAM chip select; high only while a strobe is high.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, including cpu_rdata, bus_addr and bus_wdata.
  - Wait counter cleared.
- States: IDLE, ACCESS, DONE. Every output is registered.
- IDLE:
  - With req=0, remain in IDLE with strobes low.
  - With req=1 at edge t0, latch we, cpu_addr and cpu_wdata. Region = RAM if addr[12:11]==2'b11, else ROM.
- Legal access (read anywhere, or write to RAM):
  - Go to ACCESS and load the counter with the region's WAIT value.
  - During ACCESS:
    - bus_addr and bus_wdata are held at the latched values.
    - Exactly one of bus_rd/bus_wr is high.
    - Exactly one of rom_sel/ram_sel is high.
  - ACCESS lasts WAIT+1 cycles; the counter decrements each cycle. WAIT=0 gives a single strobe cycle.
  - On a read, bus_rdata is captured into cpu_rdata at the edge that ends the last ACCESS cycle.
- Illegal write (we=1, ROM region):
  - Go directly to DONE with err=1.
  - No strobe or select is ever asserted; bus_addr is still updated.
- DONE:
  - ack=1 for exactly one cycle, with err valid; strobes and selects are low.
  - Unconditionally return to IDLE.
  - req is ignored in DONE. A new request can be sampled at the edge ending the first IDLE cycle after ack; minimum spacing is one idle cycle.
- Timing, with req sampled at edge t0:
  - Strobe is high in cycles t0+1 .. t0+1+WAIT.
  - ack is high in cycle t0+WAIT+2.
  - Illegal write: ack and err are high in cycle t0+1.
- Register hold rules:
  - cpu_rdata changes only on a completed read; writes and errors leave it unchanged.
  - err is 0 whenever ack is 0.
- req changing during ACCESS/DONE has no effect; the latched values are used.
- Boundary addresses:
  - 17FFH is ROM.
  - 1800H and 1FFFH are RAM.
  - 0000H and 1000H are ROM.
- rst_n asserted mid-access: strobes, selects and ack drop immediately (asynchronously). The access is abandoned with no ack after reset release, and the FSM restarts in IDLE.

Test Plan:
- ROM read, ROM_WAIT=2, req at t0, addr=0123H, bus_rdata=A5H -> bus_rd and rom_sel high in cycles t0+1..t0+3; ack=1 and err=0 at t0+4; cpu_rdata=A5H.
- RAM write, RAM_WAIT=1, addr=1800H, wdata=3CH -> bus_wr and ram_sel high in cycles t0+1..t0+2 with bus_wdata=3CH; ack at t0+3; cpu_rdata unchanged.
- ROM write at addr=17FFH -> ack=1 and err=1 at t0+1; bus_wr, rom_sel and ram_sel never high; next read of 1FFFH completes with err=0.
- Back-to-back: req held high continuously over two RAM reads (1FFFH then 1800H) -> second access starts one idle cycle after the first ack; each ack is exactly one cycle wide.
- rst_n pulsed low during the second ACCESS cycle of a ROM read -> bus_rd, rom_sel and ack go to 0 immediately; no ack after release; cpu_rdata=00H.
- Parameter sweep with ROM_WAIT=0 and RAM_WAIT=7 -> ROM strobe is 1 cycle with ack at t0+2; RAM strobe is 8 cycles with ack at t0+9.
